fp16_link_master: RTL and testbench



---
 rtl/fp16_link_master.sv | 121 ++++++++++++
 tb/tb_fp16_link_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fp16_link_master.sv
// Host-side master for the byte-serial FP16 multiplier link: sends A/B low byte first, waits RESP_GAP, collects the product.
// Optional build macro FP16_LINK_ZERO_BYPASS_EN: zero/subnormal operands skip the link and answer with a signed zero.
module fp16_link_master #(
  parameter int RESP_GAP = 2  // 0..15, must match the peer pipeline depth
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        link_ena,
  output logic [7:0]  link_a,
  output logic [7:0]  link_b,
  input  logic [7:0]  link_res
);

  typedef enum logic [2:0] {IDLE, SEND0, SEND1, GAP, RECV0, RECV1, RESP} state_t;

  localparam logic [3:0] GAP_LOAD = (RESP_GAP > 0) ? 4'(RESP_GAP - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [15:0] a_q, b_q, r_q;
  logic [7:0]  lo_q;
  logic [3:0]  gap_q;
  logic        accept;
  logic        bypass;

  assign accept = req_valid && (state_q == IDLE);

`ifdef FP16_LINK_ZERO_BYPASS_EN
  assign bypass = accept && ((req_a[14:10] == 5'd0) || (req_b[14:10] == 5'd0));
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs decode straight from the state register so reset clears the link lanes asynchronously.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    link_ena  = 1'b0;
    link_a    = 8'h00;
    link_b    = 8'h00;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) state_d = bypass ? RESP : SEND0;
      end
      SEND0: begin
        link_ena = 1'b1;
        link_a   = a_q[7:0];
        link_b   = b_q[7:0];
        state_d  = SEND1;
      end
      SEND1: begin
        link_ena = 1'b1;
        link_a   = a_q[15:8];
        link_b   = b_q[15:8];
        state_d  = (RESP_GAP > 0) ? GAP : RECV0;
      end
      GAP: begin
        link_ena = 1'b1;
        if (gap_q == 4'd0) state_d = RECV0;
      end
      RECV0: begin
        link_ena = 1'b1;
        state_d  = RECV1;
      end
      RECV1: begin
        link_ena = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Low result byte is staged so rsp_data only changes when the full product lands in RECV1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 16'h0000;
      b_q   <= 16'h0000;
      r_q   <= 16'h0000;
      lo_q  <= 8'h00;
      gap_q <= 4'd0;
    end else begin
      if (accept) begin
        a_q <= req_a;
        b_q <= req_b;
      end
      if (bypass)
        r_q <= {req_a[15] ^ req_b[15], 15'h0000};
      if (state_q == SEND1)
        gap_q <= GAP_LOAD;
      else if ((state_q == GAP) && (gap_q != 4'd0))
        gap_q <= gap_q - 4'd1;
      if (state_q == RECV0)
        lo_q <= link_res;
      if (state_q == RECV1)
        r_q <= {link_res, lo_q};
    end
  end

  assign rsp_data = r_q;

endmodule

// File: tb/tb_fp16_link_master.sv
// Directed bench for fp16_link_master: RESP_GAP=2 instance plus a RESP_GAP=0 instance.
// Honours FP16_LINK_ZERO_BYPASS_EN when the bundle is built with it.
module tb_fp16_link_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req_a = 16'h0, req_b = 16'h0;
  logic        req_ready, rsp_valid, busy, link_ena;
  logic [15:0] rsp_data;
  logic [7:0]  link_a, link_b;
  logic [7:0]  link_res = 8'h00;

  logic        g_req_valid = 1'b0, g_rsp_ready = 1'b0;
  logic [15:0] g_req_a = 16'h0, g_req_b = 16'h0;
  logic        g_req_ready, g_rsp_valid, g_busy, g_link_ena;
  logic [15:0] g_rsp_data;
  logic [7:0]  g_link_a, g_link_b;
  logic [7:0]  g_link_res = 8'h00;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fp16_link_master #(.RESP_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
    .link_ena(link_ena), .link_a(link_a), .link_b(link_b), .link_res(link_res)
  );

  fp16_link_master #(.RESP_GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(g_req_valid), .req_ready(g_req_ready), .req_a(g_req_a), .req_b(g_req_b),
    .rsp_valid(g_rsp_valid), .rsp_ready(g_rsp_ready), .rsp_data(g_rsp_data), .busy(g_busy),
    .link_ena(g_link_ena), .link_a(g_link_a), .link_b(g_link_b), .link_res(g_link_res)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the GAP=2 instance idle; returns at a negedge with it idle again.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input int hold, input bit keep_valid);
    req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
    chk("idle_req_ready", 16'(req_ready), 16'h1);
    @(negedge clk);  // t+1
    if (!keep_valid) req_valid = 1'b0;
    chk("s0_link_ena", 16'(link_ena), 16'h1);
    chk("s0_link_a", 16'(link_a), 16'(a[7:0]));
    chk("s0_link_b", 16'(link_b), 16'(b[7:0]));
    chk("s0_req_ready", 16'(req_ready), 16'h0);
    @(negedge clk);  // t+2
    chk("s1_link_a", 16'(link_a), 16'(a[15:8]));
    chk("s1_link_b", 16'(link_b), 16'(b[15:8]));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);  // t+3, t+4
      chk("gap_link_ena", 16'(link_ena), 16'h1);
      chk("gap_link_ab", {link_a, link_b}, 16'h0000);
    end
    @(negedge clk);  // t+5
    chk("r0_link_ena", 16'(link_ena), 16'h1);
    link_res = r[7:0];
    @(negedge clk);  // t+6
    chk("r1_link_ena", 16'(link_ena), 16'h1);
    chk("r1_rsp_valid", 16'(rsp_valid), 16'h0);
    link_res = r[15:8];
    @(negedge clk);  // t+7
    link_res = 8'hEE;
    chk("rsp_valid", 16'(rsp_valid), 16'h1);
    chk("rsp_data", rsp_data, r);
    chk("rsp_link_ena", 16'(link_ena), 16'h0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("bp_rsp_data", rsp_data, r);
      chk("bp_req_ready", 16'(req_ready), 16'h0);
      chk("bp_busy", 16'(busy), 16'h1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("done_req_ready", 16'(req_ready), 16'h1);
    chk("done_busy", 16'(busy), 16'h0);
    chk("done_rsp_hold", rsp_data, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_link", {7'h0, link_ena, link_a}, 16'h0000);
    chk("rst_link_b", 16'(link_b), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 16'(req_ready), 16'h1);

    do_txn(16'h3C00, 16'h4000, 16'h4000, 5, 1'b0);
    do_txn(16'h4200, 16'h3800, 16'h3E00, 0, 1'b1);
    do_txn(16'hC000, 16'h4400, 16'hC800, 1, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_no_reaccept", 16'(busy), 16'h0);

    // Reset in the middle of SEND1 must clear the link lanes without waiting for a clock.
    req_a = 16'h1234; req_b = 16'h5678; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_s1_link_a", 16'(link_a), 16'h0012);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_link_ena", 16'(link_ena), 16'h0);
    chk("abort_link_ab", {link_a, link_b}, 16'h0000);
    chk("abort_rsp_data", rsp_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_rsp_valid", 16'(rsp_valid), 16'h0);
      chk("abort_busy", 16'(busy), 16'h0);
      chk("abort_req_ready", 16'(req_ready), 16'h1);
    end
    do_txn(16'h3C00, 16'h3C00, 16'hA55A, 0, 1'b0);

    // RESP_GAP=0 instance: result bytes sampled at t+3 and t+4, response at t+5.
    g_req_a = 16'h4000; g_req_b = 16'h4200; g_req_valid = 1'b1;
    @(negedge clk);  // t+1
    g_req_valid = 1'b0;
    chk("g0_s0_link_a", 16'(g_link_a), 16'h0000);
    @(negedge clk);  // t+2
    chk("g0_s1_link_b", 16'(g_link_b), 16'h0042);
    @(negedge clk);  // t+3
    chk("g0_r0_link_ena", 16'(g_link_ena), 16'h1);
    chk("g0_r0_link_ab", {g_link_a, g_link_b}, 16'h0000);
    g_link_res = 8'h00;
    @(negedge clk);  // t+4
    chk("g0_r1_rsp_valid", 16'(g_rsp_valid), 16'h0);
    g_link_res = 8'h46;
    @(negedge clk);  // t+5
    g_link_res = 8'h11;
    chk("g0_rsp_valid", 16'(g_rsp_valid), 16'h1);
    chk("g0_rsp_data", g_rsp_data, 16'h4600);
    chk("g0_link_ena", 16'(g_link_ena), 16'h0);
    g_rsp_ready = 1'b1;
    @(negedge clk);
    g_rsp_ready = 1'b0;
    chk("g0_done_req_ready", 16'(g_req_ready), 16'h1);

`ifdef FP16_LINK_ZERO_BYPASS_EN
    req_a = 16'h0000; req_b = 16'hC000; req_valid = 1'b1;
    @(negedge clk);  // t+1
    req_valid = 1'b0;
    chk("byp_rsp_valid", 16'(rsp_valid), 16'h1);
    chk("byp_rsp_data", rsp_data, 16'h8000);
    chk("byp_link_ena", 16'(link_ena), 16'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("byp_done_busy", 16'(busy), 16'h0);
    chk("byp_done_link_ena", 16'(link_ena), 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
